pc_next_seq: RTL and testbench

- Drives the program counter register: supplies write_data_PC and consumes read_PC, closing the fetch loop.
- Sequences each instruction through settle, fetch and decode phases.
- Computes the next 11-bit PC for sequential execution, conditional relative branch, absolute jump, call and return.
- Call/return use a small internal return-address stack.
- Sits between the PC register, instruction memory and the decoder.

---
 rtl/pc_next_seq.sv | 187 ++++++++++++++++++
 tb/tb_pc_next_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_seq.sv
// Program-counter sequencer: settle/fetch/decode loop with next-PC selection and a return-address stack.
// Optional build macro PC_SEQ_TRACE_EN adds simulation-only trace prints of PC updates and halt causes.
module pc_next_seq #(
    parameter int                ADDR_W      = 11,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] read_PC,
    output logic [ADDR_W-1:0] write_data_PC,
    output logic              fetch_req,
    input  logic              fetch_ack,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic              cond,
    input  logic [7:0]        offset,
    input  logic [ADDR_W-1:0] target,
    output logic              halted,
    output logic              stack_err
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_req_q, fetch_req_d;
    logic              halted_q, halted_d;
    logic              stack_err_q, stack_err_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              push;
    logic [PTR_W-1:0]  top_idx;
    logic              stack_full;
    logic              stack_empty;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    // All PC arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] pc_rel(input logic [ADDR_W-1:0] pc,
                                                 input logic [7:0]        off);
        logic signed [ADDR_W-1:0] soff;
        soff = {{(ADDR_W-8){off[7]}}, off};
        return pc + $unsigned(soff);
    endfunction

    assign top_idx     = PTR_W'(sp_q - SP_W'(1));
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_req_d = fetch_req_q;
        halted_d    = halted_q;
        stack_err_d = stack_err_q;
        sp_d        = sp_q;
        push        = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_SETTLE;
            end
            // Only fetch once the PC register reflects the committed PC.
            S_SETTLE: begin
                if (read_PC == pc_q) begin
                    state_d     = S_FETCH;
                    fetch_req_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (fetch_ack) begin
                    state_d     = S_DECODE;
                    fetch_req_d = 1'b0;
                end
            end
            S_DECODE: begin
                if (op_valid) begin
                    state_d = S_SETTLE;
                    case (op)
                        OP_BRANCH: pc_d = cond ? pc_rel(pc_q, offset) : pc_inc(pc_q);
                        OP_JUMP:   pc_d = target;
                        OP_CALL: begin
                            if (stack_full) begin
                                state_d     = S_HALT;
                                halted_d    = 1'b1;
                                stack_err_d = 1'b1;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + SP_W'(1);
                                pc_d = target;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                state_d     = S_HALT;
                                halted_d    = 1'b1;
                                stack_err_d = 1'b1;
                            end else begin
                                sp_d = sp_q - SP_W'(1);
                                pc_d = stack_q[top_idx];
                            end
                        end
                        OP_HALT: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                        default:   pc_d = pc_inc(pc_q);
                    endcase
                end
            end
            S_HALT: begin
                fetch_req_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
            sp_q        <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_req_q <= fetch_req_d;
            halted_q    <= halted_d;
            stack_err_q <= stack_err_d;
            sp_q        <= sp_d;
        end
    end

    // Stack contents are only meaningful below sp_q, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            stack_q[sp_q[PTR_W-1:0]] <= pc_inc(pc_q);
        end
    end

    assign write_data_PC = pc_q;
    assign fetch_req     = fetch_req_q;
    assign halted        = halted_q;
    assign stack_err     = stack_err_q;

`ifdef PC_SEQ_TRACE_EN
    always @(posedge CLK) begin
        if (RST_N && state_q == S_DECODE && op_valid) begin
            if (state_d == S_HALT) begin
                if (op == OP_HALT)
                    $display("pc_next_seq: halt at PC %0d (0x%03h), cause HALT op", pc_q, pc_q);
                else if (op == OP_CALL)
                    $display("pc_next_seq: halt at PC %0d (0x%03h), cause stack overflow", pc_q, pc_q);
                else
                    $display("pc_next_seq: halt at PC %0d (0x%03h), cause stack underflow", pc_q, pc_q);
            end else begin
                $display("pc_next_seq: PC %0d (0x%03h, page %0d off 0x%02h) -> %0d (0x%03h, page %0d off 0x%02h)",
                         pc_q, pc_q, pc_q[ADDR_W-1:ADDR_W-3], pc_q[7:0],
                         pc_d, pc_d, pc_d[ADDR_W-1:ADDR_W-3], pc_d[7:0]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_next_seq.sv
// Directed bench for pc_next_seq, with a negedge-capturing PC register closing the fetch loop.
module tb_pc_next_seq;

    localparam int ADDR_W = 11;

    logic              CLK;
    logic              RST_N;
    logic [ADDR_W-1:0] read_PC;
    logic [ADDR_W-1:0] write_data_PC;
    logic              fetch_req;
    logic              fetch_ack;
    logic              op_valid;
    logic [2:0]        op;
    logic              cond;
    logic [7:0]        offset;
    logic [ADDR_W-1:0] target;
    logic              halted;
    logic              stack_err;

    int checks = 0;
    int errors = 0;

    pc_next_seq #(.ADDR_W(ADDR_W), .STACK_DEPTH(4), .RESET_PC(11'h000)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .read_PC      (read_PC),
        .write_data_PC(write_data_PC),
        .fetch_req    (fetch_req),
        .fetch_ack    (fetch_ack),
        .op_valid     (op_valid),
        .op           (op),
        .cond         (cond),
        .offset       (offset),
        .target       (target),
        .halted       (halted),
        .stack_err    (stack_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // PC register: captures on negedge, visible at the following posedge.
    always @(negedge CLK) read_PC <= write_data_PC;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_ack = 1'b0;
        op_valid  = 1'b0;
        op        = 3'd0;
        cond      = 1'b0;
        offset    = 8'h00;
        target    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
    endtask

    // Waits for fetch_req, acks it, then presents one op to DECODE.
    task automatic run_instr(input logic [2:0] o, input logic c, input logic [7:0] off,
                             input logic [ADDR_W-1:0] tgt);
        int n;
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait: fetch_req=%b after %0d cycles, required 1", fetch_req, n);
        end
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        op_valid  = 1'b1;
        op        = o;
        cond      = c;
        offset    = off;
        target    = tgt;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        RST_N = 1'b0;
        repeat (3) tick();
        checks++; if (write_data_PC !== 11'h000) begin errors++; $display("FAIL reset_pc: got %h required 000", write_data_PC); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req: got %b required 0", fetch_req); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_stack_err: got %b required 0", stack_err); end
        RST_N = 1'b1;
        tick();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_idle_settle: fetch_req=%b required 0", fetch_req); end
        tick();
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_first_fetch: fetch_req=%b required 1", fetch_req); end
    endtask

    // Ack and NEXT held high throughout: checks cycle-exact PC and fetch_req sequence.
    task automatic test_next_seq();
        logic [ADDR_W-1:0] exp_pc [10] = '{11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd1, 11'd2, 11'd2, 11'd2, 11'd3};
        logic              exp_fr [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        fetch_ack = 1'b1;
        op_valid  = 1'b1;
        op        = 3'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (write_data_PC !== exp_pc[i] || fetch_req !== exp_fr[i]) begin
                errors++;
                $display("FAIL next_seq_cycle%0d: pc=%h fetch_req=%b required pc=%h fetch_req=%b",
                         i + 1, write_data_PC, fetch_req, exp_pc[i], exp_fr[i]);
            end
            if (fetch_req === 1'b1) begin
                checks++;
                if (read_PC !== write_data_PC) begin
                    errors++;
                    $display("FAIL next_seq_fetch_before_settle: read_PC=%h required %h", read_PC, write_data_PC);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(3'd2, 1'b0, 8'h00, 11'h010);
        checks++; if (write_data_PC !== 11'h010) begin errors++; $display("FAIL jump_010: got %h required 010", write_data_PC); end
        run_instr(3'd1, 1'b1, 8'hF0, 11'h000);
        checks++; if (write_data_PC !== 11'h000) begin errors++; $display("FAIL branch_taken_neg: got %h required 000", write_data_PC); end
        run_instr(3'd2, 1'b0, 8'h00, 11'h010);
        run_instr(3'd1, 1'b0, 8'hF0, 11'h000);
        checks++; if (write_data_PC !== 11'h011) begin errors++; $display("FAIL branch_not_taken: got %h required 011", write_data_PC); end
        run_instr(3'd1, 1'b1, 8'h05, 11'h000);
        checks++; if (write_data_PC !== 11'h016) begin errors++; $display("FAIL branch_taken_pos: got %h required 016", write_data_PC); end
        run_instr(3'd2, 1'b0, 8'h00, 11'h7FF);
        run_instr(3'd0, 1'b0, 8'h00, 11'h000);
        checks++; if (write_data_PC !== 11'h000) begin errors++; $display("FAIL next_wrap: got %h required 000", write_data_PC); end
        run_instr(3'd2, 1'b0, 8'h00, 11'h7FE);
        run_instr(3'd1, 1'b1, 8'h7F, 11'h000);
        checks++; if (write_data_PC !== 11'h07D) begin errors++; $display("FAIL branch_wrap: got %h required 07D", write_data_PC); end
        run_instr(3'd6, 1'b1, 8'h40, 11'h555);
        checks++; if (write_data_PC !== 11'h07E) begin errors++; $display("FAIL op6_as_next: got %h required 07E", write_data_PC); end
    endtask

    task automatic test_call_ret();
        logic [ADDR_W-1:0] call_tgt [4] = '{11'h100, 11'h200, 11'h300, 11'h400};
        logic [ADDR_W-1:0] ret_exp  [4] = '{11'h301, 11'h201, 11'h101, 11'h022};
        do_reset();
        run_instr(3'd2, 1'b0, 8'h00, 11'h020);
        run_instr(3'd3, 1'b0, 8'h00, 11'h300);
        checks++; if (write_data_PC !== 11'h300) begin errors++; $display("FAIL call_300: got %h required 300", write_data_PC); end
        run_instr(3'd4, 1'b0, 8'h00, 11'h000);
        checks++; if (write_data_PC !== 11'h021) begin errors++; $display("FAIL ret_021: got %h required 021", write_data_PC); end
        for (int i = 0; i < 4; i++) begin
            run_instr(3'd3, 1'b0, 8'h00, call_tgt[i]);
            checks++;
            if (write_data_PC !== call_tgt[i]) begin
                errors++;
                $display("FAIL nested_call%0d: got %h required %h", i, write_data_PC, call_tgt[i]);
            end
        end
        checks++; if (stack_err !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL full_stack_legal: stack_err=%b halted=%b required 0 0", stack_err, halted); end
        for (int i = 0; i < 4; i++) begin
            run_instr(3'd4, 1'b0, 8'h00, 11'h000);
            checks++;
            if (write_data_PC !== ret_exp[i]) begin
                errors++;
                $display("FAIL nested_ret%0d: got %h required %h", i, write_data_PC, ret_exp[i]);
            end
        end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL unwind_stack_err: got %b required 0", stack_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        run_instr(3'd3, 1'b0, 8'h00, 11'h010);
        run_instr(3'd3, 1'b0, 8'h00, 11'h020);
        run_instr(3'd3, 1'b0, 8'h00, 11'h030);
        run_instr(3'd3, 1'b0, 8'h00, 11'h040);
        run_instr(3'd3, 1'b0, 8'h00, 11'h050);
        checks++; if (write_data_PC !== 11'h040) begin errors++; $display("FAIL overflow_pc_held: got %h required 040", write_data_PC); end
        checks++; if (stack_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL overflow_flags: stack_err=%b halted=%b required 1 1", stack_err, halted); end
        fetch_ack = 1'b1;
        op_valid  = 1'b1;
        op        = 3'd2;
        target    = 11'h222;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (fetch_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_no_fetch%0d: fetch_req=%b required 0", i, fetch_req);
            end
        end
        clear_inputs();
        checks++; if (write_data_PC !== 11'h040 || halted !== 1'b1) begin errors++; $display("FAIL halt_frozen: pc=%h halted=%b required 040 1", write_data_PC, halted); end
    endtask

    task automatic test_underflow_and_halt();
        do_reset();
        run_instr(3'd4, 1'b0, 8'h00, 11'h000);
        checks++; if (write_data_PC !== 11'h000) begin errors++; $display("FAIL underflow_pc: got %h required 000", write_data_PC); end
        checks++; if (stack_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL underflow_flags: stack_err=%b halted=%b required 1 1", stack_err, halted); end
        do_reset();
        run_instr(3'd2, 1'b0, 8'h00, 11'h123);
        run_instr(3'd5, 1'b0, 8'h00, 11'h456);
        checks++; if (write_data_PC !== 11'h123) begin errors++; $display("FAIL halt_op_pc: got %h required 123", write_data_PC); end
        checks++; if (halted !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL halt_op_flags: halted=%b stack_err=%b required 1 0", halted, stack_err); end
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        do_reset();
        run_instr(3'd2, 1'b0, 8'h00, 11'h055);
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++; if (fetch_req !== 1'b1 || write_data_PC !== 11'h055) begin errors++; $display("FAIL fetch_hold: fetch_req=%b pc=%h required 1 055", fetch_req, write_data_PC); end
        #1;
        RST_N = 1'b0;
        #1;
        checks++; if (fetch_req !== 1'b0 || write_data_PC !== 11'h000) begin errors++; $display("FAIL async_reset: fetch_req=%b pc=%h required 0 000", fetch_req, write_data_PC); end
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL restart_idle: fetch_req=%b required 0", fetch_req); end
        tick();
        checks++; if (fetch_req !== 1'b1 || write_data_PC !== 11'h000) begin errors++; $display("FAIL restart_fetch: fetch_req=%b pc=%h required 1 000", fetch_req, write_data_PC); end
    endtask

    initial begin
        RST_N = 1'b0;
        clear_inputs();
        test_reset();
        test_next_seq();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow_and_halt();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
